// File: rtl/tcdm_bank_responder.sv
// TCDM responder on a single-port SRAM bank with atomics; reads/writes respond 2 cycles after accept, atomics add one write-back cycle.
// A credit counter caps outstanding requests at the response FIFO depth, so response back-pressure stalls req_ready_o and never drops read data.
module tcdm_bank_responder #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 8,
  parameter int unsigned MetaWidth = 8,
  parameter int unsigned RespDepth = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic                   req_wen_i,
  input  logic [DataWidth/8-1:0] req_be_i,
  input  logic [DataWidth-1:0]   req_wdata_i,
  input  logic [2:0]             req_amo_i,
  input  logic [MetaWidth-1:0]   req_meta_i,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic [DataWidth-1:0]   resp_rdata_o,
  output logic [MetaWidth-1:0]   resp_meta_o,
  output logic                   bank_req_o,
  output logic                   bank_we_o,
  output logic [AddrWidth-1:0]   bank_addr_o,
  output logic [DataWidth/8-1:0] bank_be_o,
  output logic [DataWidth-1:0]   bank_wdata_o,
  input  logic [DataWidth-1:0]   bank_rdata_i
);

  localparam int unsigned BeWidth  = DataWidth / 8;
  localparam int unsigned PtrWidth = (RespDepth > 1) ? $clog2(RespDepth) : 1;
  localparam int unsigned CntWidth = $clog2(RespDepth + 1);

  localparam logic [2:0] AmoSwap = 3'd1;
  localparam logic [2:0] AmoAdd  = 3'd2;
  localparam logic [2:0] AmoAnd  = 3'd3;
  localparam logic [2:0] AmoOr   = 3'd4;
  localparam logic [2:0] AmoXor  = 3'd5;

  typedef enum logic {
    IDLE   = 1'b0,
    AMO_WB = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   outstanding_q, outstanding_d;
  logic [AddrWidth-1:0]  amo_addr_q, amo_addr_d;
  logic [DataWidth-1:0]  amo_operand_q, amo_operand_d;
  logic [2:0]            amo_op_q, amo_op_d;
  logic [MetaWidth-1:0]  amo_meta_q, amo_meta_d;
  logic                  pipe_vld_q, pipe_vld_d;
  logic                  pipe_wr_q, pipe_wr_d;
  logic [MetaWidth-1:0]  pipe_meta_q, pipe_meta_d;
  logic [DataWidth-1:0]  fifo_data_q [RespDepth];
  logic [DataWidth-1:0]  fifo_data_d [RespDepth];
  logic [MetaWidth-1:0]  fifo_meta_q [RespDepth];
  logic [MetaWidth-1:0]  fifo_meta_d [RespDepth];
  logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0]   fifo_cnt_q, fifo_cnt_d;

  logic                  resp_vld;
  logic                  pop;
  logic                  accept;
  logic                  is_amo;
  logic                  push;
  logic [DataWidth-1:0]  push_data;
  logic [MetaWidth-1:0]  push_meta;
  logic [DataWidth-1:0]  amo_result;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(RespDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign resp_vld     = (fifo_cnt_q != '0);
  assign resp_valid_o = resp_vld;
  assign resp_rdata_o = resp_vld ? fifo_data_q[rd_ptr_q] : '0;
  assign resp_meta_o  = resp_vld ? fifo_meta_q[rd_ptr_q] : '0;
  assign pop          = resp_vld && resp_ready_i;

  // A pop in the same cycle frees a credit, keeping full throughput at depth 2.
  assign req_ready_o = !rst_i && (state_q == IDLE) &&
                       ((outstanding_q < CntWidth'(RespDepth)) || pop);
  assign accept      = req_valid_i && req_ready_o;
  assign is_amo      = (req_amo_i != 3'd0);

  always_comb begin
    amo_result = bank_rdata_i;
    case (amo_op_q)
      AmoSwap: amo_result = amo_operand_q;
      AmoAdd:  amo_result = bank_rdata_i + amo_operand_q;
      AmoAnd:  amo_result = bank_rdata_i & amo_operand_q;
      AmoOr:   amo_result = bank_rdata_i | amo_operand_q;
      AmoXor:  amo_result = bank_rdata_i ^ amo_operand_q;
      default: amo_result = bank_rdata_i;
    endcase
  end

  always_comb begin
    bank_req_o   = 1'b0;
    bank_we_o    = 1'b0;
    bank_addr_o  = '0;
    bank_be_o    = '0;
    bank_wdata_o = '0;
    if (state_q == AMO_WB) begin
      bank_req_o   = 1'b1;
      bank_we_o    = 1'b1;
      bank_addr_o  = amo_addr_q;
      bank_be_o    = {BeWidth{1'b1}};
      bank_wdata_o = amo_result;
    end else if (accept) begin
      bank_req_o  = 1'b1;
      bank_addr_o = req_addr_i;
      if (!is_amo && req_wen_i) begin
        bank_we_o    = 1'b1;
        bank_be_o    = req_be_i;
        bank_wdata_o = req_wdata_i;
      end
    end
  end

  // The write-back cycle and the read/write pipeline never push in the same cycle.
  assign push      = pipe_vld_q || (state_q == AMO_WB);
  assign push_data = ((state_q == AMO_WB) || !pipe_wr_q) ? bank_rdata_i : '0;
  assign push_meta = (state_q == AMO_WB) ? amo_meta_q : pipe_meta_q;

  always_comb begin
    state_d       = state_q;
    amo_addr_d    = amo_addr_q;
    amo_operand_d = amo_operand_q;
    amo_op_d      = amo_op_q;
    amo_meta_d    = amo_meta_q;
    if (state_q == AMO_WB) begin
      state_d = IDLE;
    end else if (accept && is_amo) begin
      state_d       = AMO_WB;
      amo_addr_d    = req_addr_i;
      amo_operand_d = req_wdata_i;
      amo_op_d      = req_amo_i;
      amo_meta_d    = req_meta_i;
    end

    pipe_vld_d  = accept && !is_amo;
    pipe_wr_d   = req_wen_i;
    pipe_meta_d = req_meta_i;

    outstanding_d = outstanding_q;
    if (accept && !pop) begin
      outstanding_d = outstanding_q + CntWidth'(1);
    end else if (!accept && pop) begin
      outstanding_d = outstanding_q - CntWidth'(1);
    end

    fifo_data_d = fifo_data_q;
    fifo_meta_d = fifo_meta_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_cnt_d  = fifo_cnt_q;
    if (push) begin
      fifo_data_d[wr_ptr_q] = push_data;
      fifo_meta_d[wr_ptr_q] = push_meta;
      wr_ptr_d              = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push && !pop) begin
      fifo_cnt_d = fifo_cnt_q + CntWidth'(1);
    end else if (!push && pop) begin
      fifo_cnt_d = fifo_cnt_q - CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      outstanding_q <= '0;
      amo_addr_q    <= '0;
      amo_operand_q <= '0;
      amo_op_q      <= '0;
      amo_meta_q    <= '0;
      pipe_vld_q    <= 1'b0;
      pipe_wr_q     <= 1'b0;
      pipe_meta_q   <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
      for (int i = 0; i < RespDepth; i++) begin
        fifo_data_q[i] <= '0;
        fifo_meta_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      amo_addr_q    <= amo_addr_d;
      amo_operand_q <= amo_operand_d;
      amo_op_q      <= amo_op_d;
      amo_meta_q    <= amo_meta_d;
      pipe_vld_q    <= pipe_vld_d;
      pipe_wr_q     <= pipe_wr_d;
      pipe_meta_q   <= pipe_meta_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      fifo_data_q   <= fifo_data_d;
      fifo_meta_q   <= fifo_meta_d;
    end
  end

  assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && !pop && (fifo_cnt_q == CntWidth'(RespDepth))));

endmodule
